dtc_therm_decoder: RTL and testbench
====================================

Name: dtc_therm_decoder

Overview:
- Sequential consumer for the decision-tree classifier's 9-bit thermometer-coded class output.
- Accepts codes over a valid/ready handshake and checks that each one is a legal thermometer code.
- Emits a binary class level plus an error flag through a 2-stage, full-throughput pipeline.
- Keeps a saturating count of malformed codes for debug visibility.

Parameters:
- W, 9, thermometer code width; legal levels are 0..W.
- LW, 4, level width; must satisfy 2**LW > W.
- ERRW, 16, width of the saturating error counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream code is valid.
- in_ready  output  1  decoder can accept a code this cycle.
- in_code  input  W  thermometer code; LSB-first ones.
- out_valid  output  1  decoded result is valid.
- out_ready  input  1  downstream accepts the result.
- out_level  output  LW  decoded class level.
- out_err  output  1  in_code was not a legal thermometer code.
- clr_cnt  input  1  synchronous clear of err_cnt.
- err_cnt  output  ERRW  saturating count of erroneous results delivered.

Behaviour:
- Legal code: bits [k-1:0] are 1 and bits [W-1:k] are 0, for some k in 0..W.
  - out_level = k, out_err = 0.
- Illegal code (bubble):
  - out_level = number of consecutive ones from the LSB, i.e. the index of the lowest 0 bit.
  - out_err = 1.
  - Example: 9'b000101111 gives level 4, err 1.
- Stage 1 (s1) registers in_code on acceptance, i.e. when in_valid && in_ready.
- Stage 2 (s2) registers the decoded level and err from s1.
- Advance rule:
  - s2 loads from s1 when s1_valid && (!s2_valid || out_ready).
  - s1 loads a new code whenever it is empty or advancing.
- in_ready = !s1_valid || !s2_valid || out_ready. It is combinational from registered state; no combinational path from in_valid.
- Latency: a code accepted in cycle N appears with out_valid=1 in cycle N+2 when out_ready stays high.
- Throughput: one code per cycle sustained.
- Backpressure:
  - While out_valid && !out_ready, out_level and out_err hold stable.
  - The pipeline holds up to 2 codes; a third is refused (in_ready=0).
  - No code is lost, duplicated or reordered.
- Simultaneous output and input transfer on a full pipeline: s2 takes s1, and s1 takes the new code, in the same edge.
- err_cnt:
  - Increments by 1 on each output transfer (out_valid && out_ready) with out_err=1.
  - Saturates at 2**ERRW-1; it never wraps.
- clr_cnt=1 sets err_cnt to 0 on the next edge. It takes priority over a simultaneous increment.
- Reset, asynchronous and possible at any time including mid-transfer:
  - s1_valid=0, s2_valid=0, out_valid=0, out_level=0, out_err=0, err_cnt=0.
  - In-flight codes are discarded.
  - in_ready reads 1 after reset, because the pipeline is empty.
- Data registers do not need reset; only valid bits and outputs must be reset.

Optional Feature:
- Macro: DTC_THERM_BUBBLE_CORRECT_EN.
- Defined:
  - For illegal codes, out_level = popcount(in_code), saturated to W.
  - out_err is still 1, and err_cnt still counts the result.
  - The popcount is computed in s1-to-s2 logic with no extra latency.
- Undefined: the lowest-zero-index rule applies.
- Both variants give identical results for legal codes.

Test Plan:
- Legal codes 9'b000000000, 9'b000011111, 9'b111111111 in consecutive cycles, out_ready=1 -> levels 0, 5, 9 at cycles N+2..N+4; err=0 each; err_cnt stays 0.
- Bubble code 9'b000101111 -> without macro: level 4, err 1; with macro: level 5, err 1; err_cnt goes 0->1 on transfer.
- Stream 4 codes with out_ready=0 for 5 cycles -> in_ready falls after 2 accepts; outputs stay stable; on release all 4 arrive in order with no gaps after the first.
- ERRW=2 override with 5 bubble codes delivered -> err_cnt sequence 1, 2, 3, 3, 3.
- clr_cnt asserted in the same cycle as an erroneous output transfer with err_cnt=2 -> err_cnt=0 next cycle.
- rst_n pulsed low while both stages are valid -> out_valid=0 immediately; after release in_ready=1, and the next code decodes correctly with 2-cycle latency.

Source files
------------

// File: rtl/dtc_therm_decoder_if.sv
// Handshake bundle for the thermometer decoder: an input code stream and a
// decoded level/error result stream, each with valid/ready flow control.
interface dtc_therm_decoder_if #(
    parameter int W  = 9,
    parameter int LW = 4
);
    // A transfer happens on a rising edge where valid && ready. A producer keeps
    // valid and data stable until that transfer, and ready never depends on valid.
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_code;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] out_level;
    logic          out_err;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_level, out_err
    );

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_level, out_err
    );
endinterface

// File: rtl/dtc_therm_decoder.sv
// Two-stage thermometer-code decoder with bubble detection and a saturating error count.
// Optional DTC_THERM_BUBBLE_CORRECT_EN: malformed codes report their popcount as the level.
module dtc_therm_decoder #(
    parameter int W    = 9,
    parameter int LW   = 4,
    parameter int ERRW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    dtc_therm_decoder_if.slave  bus,
    input  logic                clr_cnt,
    output logic [ERRW-1:0]     err_cnt
);

    logic            s1_valid_q, s1_valid_d;
    logic [W-1:0]    s1_code_q,  s1_code_d;
    logic            s2_valid_q, s2_valid_d;
    logic [LW-1:0]   s2_level_q, s2_level_d;
    logic            s2_err_q,   s2_err_d;
    logic [ERRW-1:0] err_cnt_q,  err_cnt_d;

    logic            s1_load;
    logic            s2_load;
    logic            out_fire;
    logic [LW-1:0]   dec_level;
    logic            dec_err;
    logic            seen_zero;
`ifdef DTC_THERM_BUBBLE_CORRECT_EN
    logic [LW-1:0]   pop_cnt;
`endif

    // Any 1 above the lowest 0 is a bubble; the level is the run of ones from the LSB.
    always_comb begin
        dec_level = '0;
        dec_err   = 1'b0;
        seen_zero = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (!s1_code_q[i]) begin
                seen_zero = 1'b1;
            end else if (seen_zero) begin
                dec_err = 1'b1;
            end else begin
                dec_level = LW'(i + 1);
            end
        end
`ifdef DTC_THERM_BUBBLE_CORRECT_EN
        pop_cnt = '0;
        for (int i = 0; i < W; i++) begin
            pop_cnt = pop_cnt + LW'(s1_code_q[i]);
        end
        if (dec_err) begin
            dec_level = (pop_cnt > LW'(W)) ? LW'(W) : pop_cnt;
        end
`endif
    end

    assign bus.in_ready = !s1_valid_q || !s2_valid_q || bus.out_ready;
    assign s1_load      = bus.in_valid && bus.in_ready;
    assign s2_load      = s1_valid_q && (!s2_valid_q || bus.out_ready);
    assign out_fire     = s2_valid_q && bus.out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s2_valid_d = s2_valid_q;
        s2_level_d = s2_level_q;
        s2_err_d   = s2_err_q;
        err_cnt_d  = err_cnt_q;

        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_code_d  = bus.in_code;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_level_d = dec_level;
            s2_err_d   = dec_err;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end

        // Clear wins over a same-cycle increment; the count sticks at all-ones.
        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if (out_fire && s2_err_q && (err_cnt_q != {ERRW{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_level_q <= '0;
            s2_err_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s2_level_q <= s2_level_d;
            s2_err_q   <= s2_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // The captured code is qualified by s1_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        s1_code_q <= s1_code_d;
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_level = s2_level_q;
    assign bus.out_err   = s2_err_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_dtc_therm_decoder.sv
// Self-checking bench for dtc_therm_decoder: directed scenarios plus a randomized
// stream checked against a queue-based reference model.
module tb_dtc_therm_decoder;
    localparam int W    = 9;
    localparam int LW   = 4;
    localparam int ERRW = 16;
`ifdef DTC_THERM_BUBBLE_CORRECT_EN
    localparam int BUB_LVL = 5;
`else
    localparam int BUB_LVL = 4;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clr_cnt = 1'b0;
    logic            clr_cnt2 = 1'b0;
    logic [ERRW-1:0] err_cnt;
    logic [1:0]      err_cnt2;

    int total = 0;
    int bad   = 0;

    logic [LW:0]     exp_q[$];
    logic [ERRW-1:0] exp_cnt = '0;
    logic [LW:0]     mon_e;

    dtc_therm_decoder_if #(.W(W), .LW(LW)) b();
    dtc_therm_decoder_if #(.W(W), .LW(LW)) b2();

    dtc_therm_decoder #(.W(W), .LW(LW), .ERRW(ERRW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(b), .clr_cnt(clr_cnt), .err_cnt(err_cnt)
    );

    dtc_therm_decoder #(.W(W), .LW(LW), .ERRW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2), .clr_cnt(clr_cnt2), .err_cnt(err_cnt2)
    );

    always #5 clk = ~clk;

    // Reference: {err, level} from the thermometer rules, with plain counting.
    function automatic logic [LW:0] model(input logic [W-1:0] c);
        int k = 0;
        int pc = 0;
        logic err;
        while (k < W && c[k]) k++;
        for (int i = 0; i < W; i++) pc += int'(c[i]);
        err = (c != W'((1 << k) - 1));
`ifdef DTC_THERM_BUBBLE_CORRECT_EN
        if (err) k = (pc > W) ? W : pc;
`endif
        return {err, LW'(k)};
    endfunction

    function automatic logic [W-1:0] rand_code();
        int k;
        if ($urandom_range(0, 1) == 0) begin
            k = $urandom_range(0, W);
            return W'((1 << k) - 1);
        end
        return W'($urandom_range(0, (1 << W) - 1));
    endfunction

    function automatic logic [W-1:0] rand_bubble();
        logic [W-1:0] c;
        logic [LW:0]  r;
        do begin
            c = W'($urandom_range(0, (1 << W) - 1));
            r = model(c);
        end while (!r[LW]);
        return c;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the main instance: ordered results and the error count.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_e = '0;
            if (b.out_valid && b.out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_spurious got={%b,%0d} want=none", b.out_err, b.out_level);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({b.out_err, b.out_level} !== mon_e) begin
                        bad++;
                        $display("FAIL sb_result got={%b,%0d} want={%b,%0d}",
                                 b.out_err, b.out_level, mon_e[LW], mon_e[LW-1:0]);
                    end
                end
            end
            total++;
            if (err_cnt !== exp_cnt) begin
                bad++;
                $display("FAIL sb_err_cnt got=%0d want=%0d", err_cnt, exp_cnt);
            end
            if (clr_cnt) exp_cnt = '0;
            else if (b.out_valid && b.out_ready && mon_e[LW] && exp_cnt != {ERRW{1'b1}})
                exp_cnt = exp_cnt + 1'b1;
            if (b.in_valid && b.in_ready) exp_q.push_back(model(b.in_code));
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        b.in_valid = 1'b0;  b.in_code = '0;  b.out_ready = 1'b1;
        b2.in_valid = 1'b0; b2.in_code = '0; b2.out_ready = 1'b1;
        clr_cnt = 1'b0; clr_cnt2 = 1'b0;
        #12;
        total++; if (b.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", b.out_valid); end
        total++; if (b.out_level !== '0) begin bad++; $display("FAIL rst_out_level got=%0d want=0", b.out_level); end
        total++; if (b.out_err !== 1'b0) begin bad++; $display("FAIL rst_out_err got=%b want=0", b.out_err); end
        total++; if (err_cnt !== '0) begin bad++; $display("FAIL rst_err_cnt got=%0d want=0", err_cnt); end
        total++; if (err_cnt2 !== '0) begin bad++; $display("FAIL rst_err_cnt2 got=%0d want=0", err_cnt2); end
        exp_q.delete();
        exp_cnt = '0;
        cyc();
        #2 rst_n = 1'b1;
        @(negedge clk);
        total++; if (b.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", b.in_ready); end
    endtask

    task automatic test_legal();
        logic [W-1:0]  codes [3];
        logic [LW-1:0] lv [3];
        codes[0] = 9'b000000000; codes[1] = 9'b000011111; codes[2] = 9'b111111111;
        lv[0] = 4'd0; lv[1] = 4'd5; lv[2] = 4'd9;
        for (int c = 0; c < 6; c++) begin
            cyc();
            b.out_ready = 1'b1;
            b.in_valid  = (c < 3);
            if (c < 3) b.in_code = codes[c];
            @(negedge clk);
            if (c < 3) begin
                total++; if (b.in_ready !== 1'b1) begin bad++; $display("FAIL legal_in_ready c=%0d got=%b want=1", c, b.in_ready); end
            end
            if (c >= 2 && c < 5) begin
                total++; if (b.out_valid !== 1'b1) begin bad++; $display("FAIL legal_valid c=%0d got=%b want=1", c, b.out_valid); end
                total++; if (b.out_level !== lv[c-2]) begin bad++; $display("FAIL legal_level c=%0d got=%0d want=%0d", c, b.out_level, lv[c-2]); end
                total++; if (b.out_err !== 1'b0) begin bad++; $display("FAIL legal_err c=%0d got=%b want=0", c, b.out_err); end
            end else begin
                total++; if (b.out_valid !== 1'b0) begin bad++; $display("FAIL legal_idle c=%0d got=%b want=0", c, b.out_valid); end
            end
            total++; if (err_cnt !== '0) begin bad++; $display("FAIL legal_err_cnt c=%0d got=%0d want=0", c, err_cnt); end
        end
    endtask

    task automatic test_bubble();
        for (int c = 0; c < 5; c++) begin
            cyc();
            b.out_ready = 1'b1;
            b.in_valid  = (c == 0);
            b.in_code   = 9'b000101111;
            @(negedge clk);
            if (c == 2) begin
                total++; if (b.out_valid !== 1'b1) begin bad++; $display("FAIL bub_valid got=%b want=1", b.out_valid); end
                total++; if (b.out_level !== LW'(BUB_LVL)) begin bad++; $display("FAIL bub_level got=%0d want=%0d", b.out_level, BUB_LVL); end
                total++; if (b.out_err !== 1'b1) begin bad++; $display("FAIL bub_err got=%b want=1", b.out_err); end
                total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL bub_cnt_before got=%0d want=0", err_cnt); end
            end
            if (c == 3) begin
                total++; if (err_cnt !== 16'd1) begin bad++; $display("FAIL bub_cnt_after got=%0d want=1", err_cnt); end
            end
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int rcv = 0;
        int last_rx = -1;
        logic [W-1:0] code;
        code = rand_code();
        for (int c = 0; c < 30 && rcv < 4; c++) begin
            cyc();
            b.in_valid  = (sent < 4);
            b.in_code   = code;
            b.out_ready = (c >= 5);
            @(negedge clk);
            if (c < 5 && sent >= 2) begin
                total++; if (b.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c=%0d got=%b want=0", c, b.in_ready); end
            end
            if (c < 5 && b.out_valid && exp_q.size() > 0) begin
                total++;
                if ({b.out_err, b.out_level} !== exp_q[0]) begin
                    bad++;
                    $display("FAIL bp_hold c=%0d got={%b,%0d} want={%b,%0d}", c, b.out_err, b.out_level, exp_q[0][LW], exp_q[0][LW-1:0]);
                end
            end
            if (b.out_valid && b.out_ready) begin
                if (last_rx >= 0) begin
                    total++; if (c != last_rx + 1) begin bad++; $display("FAIL bp_gap got=%0d want=%0d", c, last_rx + 1); end
                end
                last_rx = c;
                rcv++;
            end
            if (b.in_valid && b.in_ready) begin
                sent++;
                code = rand_code();
            end
        end
        total++; if (rcv != 4) begin bad++; $display("FAIL bp_count got=%0d want=4", rcv); end
        cyc();
        b.in_valid = 1'b0;
        b.out_ready = 1'b1;
    endtask

    task automatic test_sat();
        logic [W-1:0] bub [5];
        int sent = 0;
        int rcv = 0;
        int exp2;
        for (int i = 0; i < 5; i++) bub[i] = rand_bubble();
        for (int c = 0; c < 10; c++) begin
            cyc();
            b2.out_ready = 1'b1;
            b2.in_valid  = (sent < 5);
            b2.in_code   = bub[(sent < 5) ? sent : 0];
            @(negedge clk);
            exp2 = (rcv > 3) ? 3 : rcv;
            total++; if (err_cnt2 !== 2'(exp2)) begin bad++; $display("FAIL sat_cnt c=%0d got=%0d want=%0d", c, err_cnt2, exp2); end
            if (b2.out_valid && b2.out_ready) begin
                total++; if (b2.out_err !== 1'b1) begin bad++; $display("FAIL sat_err c=%0d got=%b want=1", c, b2.out_err); end
                rcv++;
            end
            if (b2.in_valid && b2.in_ready) sent++;
        end
        total++; if (rcv != 5) begin bad++; $display("FAIL sat_rcv got=%0d want=5", rcv); end
        cyc();
        b2.in_valid = 1'b0;
    endtask

    task automatic test_clr();
        int tbl [8];
        tbl = '{3, 0, 0, 0, 1, 2, 0, 0};
        for (int c = 0; c < 8; c++) begin
            cyc();
            b2.out_ready = 1'b1;
            clr_cnt2     = (c == 0 || c == 5);
            b2.in_valid  = (c >= 1 && c <= 3);
            b2.in_code   = rand_bubble();
            @(negedge clk);
            if (c == 5) begin
                total++; if (!(b2.out_valid && b2.out_err)) begin bad++; $display("FAIL clr_fire got=%b%b want=11", b2.out_valid, b2.out_err); end
            end
            total++; if (err_cnt2 !== 2'(tbl[c])) begin bad++; $display("FAIL clr_cnt c=%0d got=%0d want=%0d", c, err_cnt2, tbl[c]); end
        end
        cyc();
        clr_cnt2 = 1'b0;
        b2.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] code;
        logic [LW:0]  e;
        for (int c = 0; c < 3; c++) begin
            cyc();
            b.out_ready = 1'b0;
            b.in_valid  = (c < 2);
            b.in_code   = rand_code();
        end
        @(negedge clk);
        total++; if (b.in_ready !== 1'b0) begin bad++; $display("FAIL rm_full got=%b want=0", b.in_ready); end
        cyc();
        b.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; if (b.out_valid !== 1'b0) begin bad++; $display("FAIL rm_out_valid got=%b want=0", b.out_valid); end
        exp_q.delete();
        exp_cnt = '0;
        cyc();
        #2 rst_n = 1'b1;
        @(negedge clk);
        total++; if (b.in_ready !== 1'b1) begin bad++; $display("FAIL rm_in_ready got=%b want=1", b.in_ready); end
        code = rand_code();
        e = model(code);
        for (int c = 0; c < 4; c++) begin
            cyc();
            b.out_ready = 1'b1;
            b.in_valid  = (c == 0);
            b.in_code   = code;
            @(negedge clk);
            if (c == 2) begin
                total++;
                if (!(b.out_valid === 1'b1 && {b.out_err, b.out_level} === e)) begin
                    bad++;
                    $display("FAIL rm_decode got=%b{%b,%0d} want=1{%b,%0d}", b.out_valid, b.out_err, b.out_level, e[LW], e[LW-1:0]);
                end
            end else begin
                total++; if (b.out_valid !== 1'b0) begin bad++; $display("FAIL rm_latency c=%0d got=%b want=0", c, b.out_valid); end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            cyc();
            b.in_valid  = ($urandom_range(0, 1) == 1);
            b.in_code   = rand_code();
            b.out_ready = ($urandom_range(0, 3) != 0);
            clr_cnt     = ($urandom_range(0, 31) == 0);
            @(negedge clk);
            if (b.out_ready) begin
                total++; if (b.in_ready !== 1'b1) begin bad++; $display("FAIL rnd_in_ready c=%0d got=%b want=1", c, b.in_ready); end
            end
        end
        cyc();
        b.in_valid = 1'b0;
        b.out_ready = 1'b1;
        clr_cnt = 1'b0;
        for (int c = 0; c < 6; c++) cyc();
        @(negedge clk);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_drain got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        #300000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_legal();
        test_bubble();
        test_backpressure();
        test_sat();
        test_clr();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
